// File: rtl/abcd_sweep_gen.sv
// Purpose : drives the four inputs of a combinational block through the patterns 0..15 in
//           ascending order, holding each pattern for DWELL cycles. It samples the block's
//           output f on the last dwell cycle of each pattern to build a 16-bit truth table.
// Latency : the first pattern appears 1 cycle after start is sampled. With pause low, done
//           pulses 16*DWELL+1 cycles after the start edge.
// Backpr. : pause freezes the dwell counter, the pattern and the capture. start is ignored
//           while a sweep is in progress.
//
// Build option: define TRUTH_CAPTURE_EN to implement the truth-table capture flops.
//   When the macro is not defined, truth is tied to 16'h0000, f is unused, and all
//   sequencing is unchanged.
//
// Ports:
//   clk        rising-edge clock for all logic
//   reset      synchronous, active-high reset
//   start      level-sampled sweep request, acted on only in IDLE
//   pause      holds the current pattern and the dwell count while high
//   f          output of the downstream function block
//   a,b,c,d    current pattern (a = MSB, d = LSB), zero outside RUN
//   pat_valid  a..d carry a sweep pattern (RUN)
//   busy       sweep in progress (RUN or DONE)
//   done       one-cycle pulse after pattern 15 has been sampled
//   truth      truth[p] = f sampled for pattern p
module abcd_sweep_gen #(
    parameter int unsigned DWELL      = 10,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        pat_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    state_t      state, state_nxt;
    logic [3:0]  pattern, pattern_nxt;
    logic [15:0] dwell_cnt, dwell_nxt;
    logic        sample;       // last dwell cycle of the pattern and not paused
    logic        clear_truth;  // entering RUN at pattern 0

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pattern   <= 4'd0;
            dwell_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            pattern   <= pattern_nxt;
            dwell_cnt <= dwell_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        dwell_nxt   = dwell_cnt;
        sample      = 1'b0;
        clear_truth = 1'b0;
        case (state)
            S_IDLE: begin
                pattern_nxt = 4'd0;
                dwell_nxt   = 16'd0;
                if (start) begin
                    state_nxt   = S_RUN;
                    clear_truth = 1'b1;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        sample    = 1'b1;
                        dwell_nxt = 16'd0;
                        // pattern stays at 15 through DONE; the outputs are gated by state
                        if (pattern == 4'd15) begin
                            state_nxt = S_DONE;
                        end else begin
                            pattern_nxt = pattern + 4'd1;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + 16'd1;
                    end
                end
            end
            S_DONE: begin
                pattern_nxt = 4'd0;
                dwell_nxt   = 16'd0;
                if (CONTINUOUS) begin
                    state_nxt   = S_RUN;
                    clear_truth = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                pattern_nxt = 4'd0;
                dwell_nxt   = 16'd0;
            end
        endcase
    end

    // All outputs decode registered state only; there is no path from the inputs.
    assign pat_valid    = (state == S_RUN);
    assign busy         = (state == S_RUN) || (state == S_DONE);
    assign done         = (state == S_DONE);
    assign {a, b, c, d} = (state == S_RUN) ? pattern : 4'd0;

`ifdef TRUTH_CAPTURE_EN
    logic [15:0] truth_q;

    always_ff @(posedge clk) begin
        if (reset || clear_truth) begin
            truth_q <= 16'h0000;
        end else if (sample) begin
            truth_q[pattern] <= f;
        end
    end

    assign truth = truth_q;
`else
    logic unused_capture;
    assign unused_capture = f ^ sample ^ clear_truth;
    assign truth          = 16'h0000;
`endif

endmodule
